// File: rtl/sa_psum_drain_if.sv
// ============================================================================
// Module   : sa_psum_drain_if
// Brief    : Control, psum-row input and drained-column output bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sa_psum_drain_if #(
    parameter int N     = 8,
    parameter int COLS  = 8,
    parameter int IDX_W = 3
);
    logic                  start;
    logic [3:0]            num_pass;
    logic [3:0]            shift;
    logic                  in_valid;
    logic [COLS*2*N-1:0]   in_psum;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_data;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  ovf;

    modport slave (
        input  start, num_pass, shift, in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy, ovf
    );

    modport master (
        output start, num_pass, shift, in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy, ovf
    );
endinterface

`default_nettype wire

// File: rtl/sa_psum_drain.sv
// ============================================================================
// Module   : sa_psum_drain
// Brief    : Multi-pass psum accumulation, rounding requantization with
//            saturation, and per-column valid/ready drain.
//            Optional macro SA_DRAIN_RELU_EN inserts ReLU before saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_psum_drain #(
    parameter int N     = 8,
    parameter int COLS  = 8,
    parameter int ACC_W = 24,
    parameter int IDX_W = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sa_psum_drain_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int                     c_PW   = 2 * N;
    localparam logic signed [ACC_W:0]  c_QMAX = (ACC_W+1)'(2**(N-1) - 1);
    localparam logic signed [ACC_W:0]  c_QMIN = ~c_QMAX;
    localparam logic [IDX_W-1:0]       c_LAST = IDX_W'(COLS - 1);

    logic [1:0]               r_state;
    logic signed [ACC_W-1:0]  r_acc [COLS];
    logic [3:0]               r_pass_cnt;
    logic [3:0]               r_num_pass;
    logic [3:0]               r_shift;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_ovf;

    logic                     w_in_fire;
    logic                     w_out_fire;
    logic signed [ACC_W:0]    w_ext;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_r;
    logic [N-1:0]             w_q;
    logic                     w_clamp;

    assign w_in_fire  = (r_state == S_ACCUM) && bus.in_valid;
    assign w_out_fire = (r_state == S_DRAIN) && bus.out_ready;

    // Round half up, arithmetic shift, then clamp to the signed N-bit range.
    always_comb begin
        w_ext = {r_acc[r_idx][ACC_W-1], r_acc[r_idx]};
        w_rnd = '0;
        if (r_shift != 4'd0) begin
            w_rnd = (ACC_W+1)'(1) << (r_shift - 4'd1);
        end
        w_sum = w_ext + w_rnd;
        w_r   = w_sum >>> r_shift;
`ifdef SA_DRAIN_RELU_EN
        if (w_r < 0) begin
            w_r = '0;
        end
`endif
        w_clamp = 1'b0;
        w_q     = w_r[N-1:0];
        if (w_r > c_QMAX) begin
            w_q     = c_QMAX[N-1:0];
            w_clamp = 1'b1;
        end else if (w_r < c_QMIN) begin
            w_q     = c_QMIN[N-1:0];
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pass_cnt <= '0;
            r_num_pass <= 4'd1;
            r_shift    <= '0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            for (int k = 0; k < COLS; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_num_pass <= (bus.num_pass == 4'd0) ? 4'd1 : bus.num_pass;
                        r_shift    <= bus.shift;
                        r_pass_cnt <= '0;
                        r_idx      <= '0;
                        r_ovf      <= 1'b0;
                        r_state    <= S_ACCUM;
                        for (int k = 0; k < COLS; k++) begin
                            r_acc[k] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_in_fire) begin
                        for (int k = 0; k < COLS; k++) begin
                            r_acc[k] <= r_acc[k] + ACC_W'($signed(bus.in_psum[k*c_PW +: c_PW]));
                        end
                        r_pass_cnt <= r_pass_cnt + 4'd1;
                        if (r_pass_cnt == r_num_pass - 4'd1) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_clamp) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_out_fire) begin
                        if (r_idx == c_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.out_data  = (r_state == S_DRAIN) ? w_q : '0;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = (r_state == S_DRAIN) && (r_idx == c_LAST);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sa_psum_drain.sv
// ============================================================================
// Module   : tb_sa_psum_drain
// Brief    : Scoreboard bench for sa_psum_drain with directed and random tiles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sa_psum_drain;
    localparam int N = 8, COLS = 8, ACC_W = 24, IDX_W = 3;

    typedef struct {
        int data;
        int idx;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   tile_rows [16][COLS];
    bit   exp_ovf;
    bit   stall_prev = 1'b0;
    int   prev_data, prev_idx;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    sa_psum_drain_if #(.N(N), .COLS(COLS), .IDX_W(IDX_W)) vif ();

    sa_psum_drain #(.N(N), .COLS(COLS), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_q(input longint s, input int sh, output bit clamp);
        longint r, d;
        clamp = 1'b0;
        if (sh == 0) begin
            r = s;
        end else begin
            d = longint'(1) << sh;
            r = s + d / 2;
            r = (r >= 0) ? r / d : -((-r + d - 1) / d);
        end
`ifdef SA_DRAIN_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) begin r = 127; clamp = 1'b1; end
        if (r < -128) begin r = -128; clamp = 1'b1; end
        return int'(r);
    endfunction

    // Consumer readiness: always, random, or held off.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       vif.out_ready = 1'b1;
            1:       vif.out_ready = ($urandom_range(0, 3) != 0);
            default: vif.out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        if (!reset && vif.out_valid) begin
            chk("in_ready_during_drain", vif.in_ready, 0);
            if (stall_prev) begin
                chk("hold_data", $signed(vif.out_data), prev_data);
                chk("hold_idx", vif.out_idx, prev_idx);
            end
            if (vif.out_ready) begin
                stall_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", vif.out_idx, -1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_data", $signed(vif.out_data), e.data);
                    chk("out_idx", vif.out_idx, e.idx);
                    chk("out_last", vif.out_last, e.last);
                end
            end else begin
                stall_prev = 1'b1;
                prev_data  = $signed(vif.out_data);
                prev_idx   = vif.out_idx;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_row(input int p);
        int t = 0;
        vif.in_valid = 1'b1;
        for (int k = 0; k < COLS; k++) vif.in_psum[k*16 +: 16] = 16'(tile_rows[p][k]);
        @(negedge clk);
        while (!vif.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
    endtask

    task automatic issue_tile(input int np, input int sh, input bit poke, input bit gaps);
        int  nrows;
        bit  cl;
        nrows   = (np == 0) ? 1 : np;
        exp_ovf = 1'b0;
        for (int k = 0; k < COLS; k++) begin
            longint s = 0;
            beat_t  e;
            for (int p = 0; p < nrows; p++) s += tile_rows[p][k];
            e.data = ref_q(s, sh, cl);
            e.idx  = k;
            e.last = (k == COLS - 1);
            exp_ovf |= cl;
            exp_q.push_back(e);
        end
        vif.start    = 1'b1;
        vif.num_pass = 4'(np);
        vif.shift    = 4'(sh);
        @(posedge clk);
        #1 vif.start = 1'b0;
        for (int p = 0; p < nrows; p++) begin
            if (poke && p > 0) begin
                vif.start = 1'b1;
                vif.num_pass = 4'd1;
                vif.shift = 4'd0;
                @(posedge clk);
                #1 vif.start = 1'b0;
            end
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
            send_row(p);
        end
        chk("out_valid_latency", vif.out_valid, 1);
        if (poke) begin
            vif.start = 1'b1;
            vif.num_pass = 4'd1;
            repeat (2) @(posedge clk);
            #1 vif.start = 1'b0;
        end
    endtask

    task automatic finish_tile();
        int t = 0;
        @(negedge clk);
        while (vif.busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 0, 1);
        chk("ovf", vif.ovf, exp_ovf);
        chk("beats_remaining", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int idx);
        int t = 0;
        @(negedge clk);
        while (!(vif.out_valid && vif.out_idx == IDX_W'(idx)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_idx_timeout", 0, 1);
    endtask

    task automatic clear_tile();
        for (int p = 0; p < 16; p++)
            for (int k = 0; k < COLS; k++) tile_rows[p][k] = 0;
    endtask

    initial begin
        reset = 1'b1;
        vif.start = 1'b0; vif.num_pass = '0; vif.shift = '0;
        vif.in_valid = 1'b0; vif.in_psum = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", vif.out_valid, 0);
        chk("rst_in_ready", vif.in_ready, 0);
        chk("rst_busy", vif.busy, 0);
        chk("rst_ovf", vif.ovf, 0);
        chk("rst_out_data", vif.out_data, 0);
        chk("rst_out_last", vif.out_last, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single pass, column k = k+1.
        clear_tile();
        for (int k = 0; k < COLS; k++) tile_rows[0][k] = k + 1;
        issue_tile(1, 0, 1'b0, 1'b0);
        finish_tile();

        // Three passes with rounding shift.
        clear_tile();
        tile_rows[0][0] = 20; tile_rows[1][0] = 21; tile_rows[2][0] = 21;
        for (int p = 0; p < 3; p++) begin
            tile_rows[p][1] = 20;
            tile_rows[p][2] = -10;
        end
        issue_tile(3, 2, 1'b0, 1'b1);
        finish_tile();

        // Saturation on both ends.
        clear_tile();
        tile_rows[0][0] = 32767; tile_rows[1][0] = 32767;
        tile_rows[0][1] = -150;  tile_rows[1][1] = -150;
        issue_tile(2, 0, 1'b0, 1'b0);
        finish_tile();

        // Negative clamp alone decides ovf.
        clear_tile();
        tile_rows[0][3] = -300;
        issue_tile(1, 0, 1'b0, 1'b0);
        finish_tile();

        // Backpressure at column 2 with ignored input pulses.
        clear_tile();
        for (int k = 0; k < COLS; k++) tile_rows[0][k] = 10 * k - 30;
        issue_tile(1, 1, 1'b0, 1'b0);
        wait_idx(1);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vif.in_valid = 1'b1;
            vif.in_psum  = {COLS{16'h7FFF}};
            @(negedge clk);
            chk("bp_idx", vif.out_idx, 2);
            chk("bp_in_ready", vif.in_ready, 0);
        end
        vif.in_valid = 1'b0;
        rdy_mode = 0;
        finish_tile();

        // Reset mid-drain aborts the tile.
        clear_tile();
        tile_rows[0][0] = 32767; tile_rows[1][0] = 32767;
        issue_tile(2, 0, 1'b0, 1'b0);
        wait_idx(3);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", vif.out_valid, 0);
        chk("abort_busy", vif.busy, 0);
        chk("abort_ovf", vif.ovf, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // num_pass=0 takes exactly one row; extra rows during drain are dropped.
        clear_tile();
        for (int k = 0; k < COLS; k++) tile_rows[0][k] = 3 * k - 7;
        issue_tile(0, 0, 1'b0, 1'b0);
        vif.in_valid = 1'b1;
        vif.in_psum  = {COLS{16'h0100}};
        repeat (4) @(posedge clk);
        #1 vif.in_valid = 1'b0;
        finish_tile();

        // start during ACCUM and DRAIN has no effect.
        clear_tile();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < COLS; k++) tile_rows[p][k] = 5 * k + p - 9;
        issue_tile(3, 1, 1'b1, 1'b0);
        finish_tile();

        // Randomised tiles with random consumer readiness.
        rdy_mode = 1;
        for (int t = 0; t < 25; t++) begin
            int np, sh, nrows;
            bit wide;
            np    = $urandom_range(0, 15);
            sh    = $urandom_range(0, 15);
            wide  = ($urandom_range(0, 1) == 1);
            nrows = (np == 0) ? 1 : np;
            clear_tile();
            for (int p = 0; p < nrows; p++)
                for (int k = 0; k < COLS; k++)
                    tile_rows[p][k] = wide ? int'($urandom_range(0, 65535)) - 32768
                                           : int'($urandom_range(0, 600)) - 300;
            issue_tile(np, sh, 1'b0, 1'b1);
            finish_tile();
        end
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
